// File: rtl/tmr_recovery_voter_pkg.sv
`default_nettype none
// ============================================================================
// Module : tmr_recovery_voter_pkg
// Desc   : Shared state encodings, lane indices and helpers for the TMR voter.
// Rev    : 1.0
// ============================================================================
package tmr_recovery_voter_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_RESYNC   = 2'd2,
    ST_FATAL    = 2'd3
  } state_e;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;

  function automatic logic [2:0] lane_onehot(input logic [1:0] lane);
    return 3'b001 << lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_recovery_voter_maj3.sv
`default_nettype none
// ============================================================================
// Module : tmr_maj3
// Desc   : Bitwise 2-of-3 majority with a per-input "differs from vote" flag.
// Rev    : 1.0
// ============================================================================
module tmr_maj3 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o,
  output logic [2:0]   mis_o
);

  assign y_o   = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
  assign mis_o = {(c_i != y_o), (b_i != y_o), (a_i != y_o)};

endmodule
`default_nettype wire

// File: rtl/tmr_recovery_voter.sv
`default_nettype none
// ============================================================================
// Module : tmr_recovery_voter
// Desc   : Zero-latency TMR lane voter with fault tracking, resync handshake
//          and PC rollback to the last unanimously agreed PC.
// Rev    : 1.0
// ============================================================================
module tmr_recovery_voter
  import tmr_recovery_voter_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter int              DATA_W       = 32,
  parameter int              FAULT_THRESH = 4,
  parameter int              ERR_CNT_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC     = '0
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [PC_W-1:0]      PC_Top_A,
  input  logic [PC_W-1:0]      PC_Top_B,
  input  logic [PC_W-1:0]      PC_Top_C,
  input  logic [DATA_W-1:0]    ALUResult_A,
  input  logic [DATA_W-1:0]    ALUResult_B,
  input  logic [DATA_W-1:0]    ALUResult_C,
  input  logic [DATA_W-1:0]    RD2_Top_A,
  input  logic [DATA_W-1:0]    RD2_Top_B,
  input  logic [DATA_W-1:0]    RD2_Top_C,
  input  logic                 MemWrite_A,
  input  logic                 MemWrite_B,
  input  logic                 MemWrite_C,
  input  logic                 resync_ack,
  output logic [PC_W-1:0]      PC_Top,
  output logic [DATA_W-1:0]    ALUResult,
  output logic [DATA_W-1:0]    RD2_Top,
  output logic                 MemWrite,
  output logic [2:0]           Voter_state,
  output logic                 resync_req,
  output logic [2:0]           resync_lane,
  output logic                 fatal,
  output logic [ERR_CNT_W-1:0] err_cnt_a,
  output logic [ERR_CNT_W-1:0] err_cnt_b,
  output logic [ERR_CNT_W-1:0] err_cnt_c
);

  localparam int                  CONSEC_W = $clog2(FAULT_THRESH + 1);
  localparam logic [CONSEC_W-1:0] C_THRESH = CONSEC_W'(FAULT_THRESH);
  localparam logic [CONSEC_W-1:0] C_ONE    = CONSEC_W'(1);

  logic [PC_W-1:0]   w_pc;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_rd2;
  logic              w_mw;
  logic [2:0]        w_mis_pc, w_mis_alu, w_mis_rd2, w_mis_mw;

  tmr_maj3 #(.W(PC_W))   u_maj_pc  (.a_i(PC_Top_A),    .b_i(PC_Top_B),    .c_i(PC_Top_C),    .y_o(w_pc),  .mis_o(w_mis_pc));
  tmr_maj3 #(.W(DATA_W)) u_maj_alu (.a_i(ALUResult_A), .b_i(ALUResult_B), .c_i(ALUResult_C), .y_o(w_alu), .mis_o(w_mis_alu));
  tmr_maj3 #(.W(DATA_W)) u_maj_rd2 (.a_i(RD2_Top_A),   .b_i(RD2_Top_B),   .c_i(RD2_Top_C),   .y_o(w_rd2), .mis_o(w_mis_rd2));
  tmr_maj3 #(.W(1))      u_maj_mw  (.a_i(MemWrite_A),  .b_i(MemWrite_B),  .c_i(MemWrite_C),  .y_o(w_mw),  .mis_o(w_mis_mw));

  logic [2:0] w_outvoted;
  logic       w_no_major, w_all_agree, w_single;
  logic [1:0] w_fault_lane;

  assign w_outvoted  = w_mis_pc | w_mis_alu | w_mis_rd2 | w_mis_mw;
  assign Voter_state = {({PC_Top_A, ALUResult_A, RD2_Top_A, MemWrite_A} == {PC_Top_B, ALUResult_B, RD2_Top_B, MemWrite_B}),
                        ({PC_Top_B, ALUResult_B, RD2_Top_B, MemWrite_B} == {PC_Top_C, ALUResult_C, RD2_Top_C, MemWrite_C}),
                        ({PC_Top_A, ALUResult_A, RD2_Top_A, MemWrite_A} == {PC_Top_C, ALUResult_C, RD2_Top_C, MemWrite_C})};
  assign w_no_major   = (Voter_state == 3'b000);
  assign w_all_agree  = (Voter_state == 3'b111);
  assign w_single     = (w_outvoted == 3'b001) || (w_outvoted == 3'b010) || (w_outvoted == 3'b100);
  assign w_fault_lane = w_outvoted[0] ? LANE_A : (w_outvoted[1] ? LANE_B : LANE_C);

  state_e              state_q;
  logic [1:0]          flt_lane_q;
  logic [CONSEC_W-1:0] consec_q;
  logic                resync_req_q;
  logic [2:0]          resync_lane_q;
  logic                fatal_q;
  logic [PC_W-1:0]     last_good_pc_q;

  // Registered outputs are updated alongside the state they describe.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_NORMAL;
      flt_lane_q    <= LANE_A;
      consec_q      <= '0;
      resync_req_q  <= 1'b0;
      resync_lane_q <= 3'b000;
      fatal_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_NORMAL, ST_DEGRADED: begin
          if (valid_in) begin
            if (w_no_major) begin
              state_q <= ST_FATAL;
              fatal_q <= 1'b1;
            end else if (w_all_agree) begin
              state_q  <= ST_NORMAL;
              consec_q <= '0;
            end else if (w_single) begin
              if (state_q == ST_DEGRADED && w_fault_lane == flt_lane_q) begin
                consec_q <= consec_q + C_ONE;
                if ((consec_q + C_ONE) == C_THRESH) begin
                  state_q       <= ST_RESYNC;
                  resync_req_q  <= 1'b1;
                  resync_lane_q <= lane_onehot(flt_lane_q);
                end
              end else begin
                flt_lane_q <= w_fault_lane;
                consec_q   <= C_ONE;
                if (FAULT_THRESH == 1) begin
                  state_q       <= ST_RESYNC;
                  resync_req_q  <= 1'b1;
                  resync_lane_q <= lane_onehot(w_fault_lane);
                end else begin
                  state_q <= ST_DEGRADED;
                end
              end
            end
          end
        end
        ST_RESYNC: begin
          if (valid_in && w_no_major) begin
            state_q       <= ST_FATAL;
            fatal_q       <= 1'b1;
            resync_req_q  <= 1'b0;
            resync_lane_q <= 3'b000;
          end else if (resync_ack) begin
            state_q       <= ST_NORMAL;
            consec_q      <= '0;
            resync_req_q  <= 1'b0;
            resync_lane_q <= 3'b000;
          end
        end
        default: begin
          state_q <= ST_FATAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in)
      last_good_pc_q <= RESET_PC;
    else if (valid_in && w_all_agree)
      last_good_pc_q <= w_pc;
  end

  logic [ERR_CNT_W-1:0] err_cnt_q [3];
  logic [ERR_CNT_W-1:0] err_cnt_d [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_err_cnt
    always_comb begin
      err_cnt_d[gi] = err_cnt_q[gi];
      if (valid_in && w_outvoted[gi] && state_q != ST_FATAL && err_cnt_q[gi] != '1)
        err_cnt_d[gi] = err_cnt_q[gi] + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in)
        err_cnt_q[gi] <= '0;
      else
        err_cnt_q[gi] <= err_cnt_d[gi];
    end
  end

  logic w_hold;
  assign w_hold = (state_q == ST_RESYNC) || (state_q == ST_FATAL);

  assign PC_Top      = w_hold ? last_good_pc_q : w_pc;
  assign ALUResult   = w_alu;
  assign RD2_Top     = w_rd2;
  assign MemWrite    = w_mw & ~w_hold;
  assign resync_req  = resync_req_q;
  assign resync_lane = resync_lane_q;
  assign fatal       = fatal_q;
  assign err_cnt_a   = err_cnt_q[0];
  assign err_cnt_b   = err_cnt_q[1];
  assign err_cnt_c   = err_cnt_q[2];

endmodule
`default_nettype wire

// File: tb/tb_tmr_recovery_voter.sv
`default_nettype none
// ============================================================================
// Module : tb_tmr_recovery_voter
// Desc   : Table-driven bench for tmr_recovery_voter with a scoreboard queue.
// Rev    : 1.0
// ============================================================================
module tb_tmr_recovery_voter;

  localparam logic [31:0] ALU_B = 32'hAAAA_5555;
  localparam logic [31:0] RD2_B = 32'h0000_1234;
  localparam int F_PC = 0, F_ALU = 1, F_RD2 = 2, F_MW = 3, F_DIST = 4;

  typedef struct {
    logic        rst, valid, ack;
    logic [31:0] base;
    int          fl, fld;
    logic [31:0] e_pc;
    logic        e_mw;
    logic [2:0]  e_vs;
    logic        e_req;
    logic [2:0]  e_lane;
    logic        e_fat;
    int          e_ea, e_eb, e_ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic        resync_ack = 1'b0;
  logic [31:0] pc_l [3];
  logic [31:0] alu_l [3];
  logic [31:0] rd2_l [3];
  logic        mw_l [3];

  logic [31:0] pc_o, alu_o, rd2_o, pc2_o, alu2_o, rd22_o;
  logic        mw_o, req_o, fat_o, mw2_o, req2_o, fat2_o;
  logic [2:0]  vs_o, lane_o, vs2_o, lane2_o;
  logic [7:0]  ea_o, eb_o, ec_o;
  logic [1:0]  ea2_o, eb2_o, ec2_o;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tmr_recovery_voter dut (
    .clk(clk), .rst_in(rst_in), .valid_in(valid_in),
    .PC_Top_A(pc_l[0]), .PC_Top_B(pc_l[1]), .PC_Top_C(pc_l[2]),
    .ALUResult_A(alu_l[0]), .ALUResult_B(alu_l[1]), .ALUResult_C(alu_l[2]),
    .RD2_Top_A(rd2_l[0]), .RD2_Top_B(rd2_l[1]), .RD2_Top_C(rd2_l[2]),
    .MemWrite_A(mw_l[0]), .MemWrite_B(mw_l[1]), .MemWrite_C(mw_l[2]),
    .resync_ack(resync_ack),
    .PC_Top(pc_o), .ALUResult(alu_o), .RD2_Top(rd2_o), .MemWrite(mw_o),
    .Voter_state(vs_o), .resync_req(req_o), .resync_lane(lane_o), .fatal(fat_o),
    .err_cnt_a(ea_o), .err_cnt_b(eb_o), .err_cnt_c(ec_o)
  );

  tmr_recovery_voter #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_in(rst_in), .valid_in(valid_in),
    .PC_Top_A(pc_l[0]), .PC_Top_B(pc_l[1]), .PC_Top_C(pc_l[2]),
    .ALUResult_A(alu_l[0]), .ALUResult_B(alu_l[1]), .ALUResult_C(alu_l[2]),
    .RD2_Top_A(rd2_l[0]), .RD2_Top_B(rd2_l[1]), .RD2_Top_C(rd2_l[2]),
    .MemWrite_A(mw_l[0]), .MemWrite_B(mw_l[1]), .MemWrite_C(mw_l[2]),
    .resync_ack(resync_ack),
    .PC_Top(pc2_o), .ALUResult(alu2_o), .RD2_Top(rd22_o), .MemWrite(mw2_o),
    .Voter_state(vs2_o), .resync_req(req2_o), .resync_lane(lane2_o), .fatal(fat2_o),
    .err_cnt_a(ea2_o), .err_cnt_b(eb2_o), .err_cnt_c(ec2_o)
  );

  function automatic vec_t mk(input logic rst, input logic valid, input logic ack,
                              input logic [31:0] base, input int fl, input int fld,
                              input logic [31:0] e_pc, input logic e_mw, input logic [2:0] e_vs,
                              input logic e_req, input logic [2:0] e_lane, input logic e_fat,
                              input int e_ea, input int e_eb, input int e_ec);
    vec_t v;
    v.rst = rst; v.valid = valid; v.ack = ack; v.base = base; v.fl = fl; v.fld = fld;
    v.e_pc = e_pc; v.e_mw = e_mw; v.e_vs = e_vs; v.e_req = e_req; v.e_lane = e_lane;
    v.e_fat = e_fat; v.e_ea = e_ea; v.e_eb = e_eb; v.e_ec = e_ec;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_in     = v.rst;
    valid_in   = v.valid;
    resync_ack = v.ack;
    for (int l = 0; l < 3; l++) begin
      pc_l[l]  = v.base;
      alu_l[l] = ALU_B;
      rd2_l[l] = RD2_B;
      mw_l[l]  = 1'b1;
      if (v.fl == l + 1) begin
        case (v.fld)
          F_PC:    pc_l[l]  = v.base ^ 32'h4;
          F_ALU:   alu_l[l] = ALU_B ^ 32'h20;
          F_RD2:   rd2_l[l] = RD2_B ^ 32'h1;
          default: mw_l[l]  = 1'b0;
        endcase
      end
    end
    if (v.fld == F_DIST) begin
      pc_l[0] = 32'h10;
      pc_l[1] = 32'h20;
      pc_l[2] = 32'h30;
    end
  endtask

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row%0d %s: got %0h expected %0h", row, nm, act, exp);
    end
  endtask

  task automatic check_vec(input int row, input vec_t e);
    chk("PC_Top", row, 64'(pc_o), 64'(e.e_pc));
    chk("ALUResult", row, 64'(alu_o), 64'(ALU_B));
    chk("RD2_Top", row, 64'(rd2_o), 64'(RD2_B));
    chk("MemWrite", row, 64'(mw_o), 64'(e.e_mw));
    chk("Voter_state", row, 64'(vs_o), 64'(e.e_vs));
    chk("resync_req", row, 64'(req_o), 64'(e.e_req));
    chk("resync_lane", row, 64'(lane_o), 64'(e.e_lane));
    chk("fatal", row, 64'(fat_o), 64'(e.e_fat));
    chk("err_cnt_a", row, 64'(ea_o), 64'(e.e_ea));
    chk("err_cnt_b", row, 64'(eb_o), 64'(e.e_eb));
    chk("err_cnt_c", row, 64'(ec_o), 64'(e.e_ec));
  endtask

  vec_t tv [$];
  vec_t sb [$];

  initial begin
    for (int l = 0; l < 3; l++) begin
      pc_l[l] = 32'h100; alu_l[l] = ALU_B; rd2_l[l] = RD2_B; mw_l[l] = 1'b1;
    end

    // rst valid ack base fl fld | pc mw vs req lane fatal | ea eb ec
    tv.push_back(mk(1,1,0,32'h100,0,F_PC,  32'h100,1,3'b111,0,3'b000,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h100,0,F_PC,  32'h100,1,3'b111,0,3'b000,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h100,2,F_ALU, 32'h100,1,3'b001,0,3'b000,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h100,0,F_PC,  32'h100,1,3'b111,0,3'b000,0, 0,1,0));
    tv.push_back(mk(0,1,0,32'h100,1,F_RD2, 32'h100,1,3'b010,0,3'b000,0, 0,1,0));
    tv.push_back(mk(0,1,0,32'h100,2,F_MW,  32'h100,1,3'b001,0,3'b000,0, 1,1,0));
    tv.push_back(mk(0,1,0,32'h100,1,F_PC,  32'h100,1,3'b010,0,3'b000,0, 1,2,0));
    tv.push_back(mk(0,1,0,32'h100,2,F_ALU, 32'h100,1,3'b001,0,3'b000,0, 2,2,0));
    tv.push_back(mk(0,0,0,32'h100,1,F_PC,  32'h100,1,3'b010,0,3'b000,0, 2,3,0));
    tv.push_back(mk(0,0,0,32'h100,3,F_ALU, 32'h100,1,3'b100,0,3'b000,0, 2,3,0));
    tv.push_back(mk(0,1,0,32'h100,0,F_PC,  32'h100,1,3'b111,0,3'b000,0, 2,3,0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(0,1,0,32'h200,3,F_PC, 32'h200,1,3'b100,0,3'b000,0, 2,3,k));
    tv.push_back(mk(0,1,0,32'h200,3,F_PC,  32'h100,0,3'b100,1,3'b100,0, 2,3,4));
    tv.push_back(mk(0,0,1,32'h200,0,F_PC,  32'h100,0,3'b111,1,3'b100,0, 2,3,5));
    tv.push_back(mk(0,1,0,32'h200,0,F_PC,  32'h200,1,3'b111,0,3'b000,0, 2,3,5));
    tv.push_back(mk(0,1,1,32'h200,1,F_ALU, 32'h200,1,3'b010,0,3'b000,0, 2,3,5));
    tv.push_back(mk(0,1,0,32'h200,0,F_PC,  32'h200,1,3'b111,0,3'b000,0, 3,3,5));
    tv.push_back(mk(0,1,0,32'h200,0,F_DIST,32'h30, 1,3'b000,0,3'b000,0, 3,3,5));
    tv.push_back(mk(0,1,0,32'h300,3,F_PC,  32'h200,0,3'b100,0,3'b000,1, 4,4,5));
    tv.push_back(mk(0,1,1,32'h300,3,F_PC,  32'h200,0,3'b100,0,3'b000,1, 4,4,5));
    tv.push_back(mk(1,1,0,32'h300,3,F_PC,  32'h300,1,3'b100,0,3'b000,0, 0,0,0));
    tv.push_back(mk(0,1,0,32'h300,0,F_PC,  32'h300,1,3'b111,0,3'b000,0, 0,0,0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(0,1,0,32'h300,1,F_ALU, 32'h300,1,3'b010,0,3'b000,0, k,0,0));
    tv.push_back(mk(0,1,0,32'h300,1,F_ALU, 32'h300,0,3'b010,1,3'b001,0, 4,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      sb.push_back(tv[i]);
      #2;
      check_vec(i, sb.pop_front());
    end

    // Saturation on the narrow-counter instance, then async reset inside RESYNC.
    @(posedge clk);
    #1;
    chk("sat err_cnt_a wide", 100, 64'(ea_o), 64'd5);
    chk("sat err_cnt_a narrow", 100, 64'(ea2_o), 64'd3);
    chk("resync_req before rst", 100, 64'(req_o), 64'd1);
    chk("narrow resync_lane", 100, 64'(lane2_o), 64'b001);
    #1 rst_in = 1'b1;
    #1;
    chk("async rst resync_req", 101, 64'(req_o), 64'd0);
    chk("async rst resync_lane", 101, 64'(lane_o), 64'd0);
    chk("async rst narrow req", 101, 64'(req2_o), 64'd0);
    chk("async rst err_cnt_a", 101, 64'(ea_o), 64'd0);
    chk("async rst MemWrite", 101, 64'(mw_o), 64'd1);
    @(negedge clk);
    rst_in = 1'b0;
    #2;
    chk("post rst PC_Top", 102, 64'(pc_o), 64'h300);
    chk("post rst fatal", 102, 64'(fat_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
